// File: rtl/skin_seg_ctrl.sv
// Control block for the skin-colour segmentation pipeline: shadowed thresholds that
// commit at frame boundaries, active-video timing measurement and lock detection.
module skin_seg_ctrl #(
   parameter int CB_MIN_DEF  = 77,
   parameter int CB_MAX_DEF  = 127,
   parameter int CR_MIN_DEF  = 133,
   parameter int CR_MAX_DEF  = 173,
   parameter int W_BITS      = 12,
   parameter int H_BITS      = 11,
   parameter int LOCK_FRAMES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_de,
   input  logic              in_vsync,
   input  logic              cfg_we,
   input  logic [2:0]        cfg_addr,
   input  logic [7:0]        cfg_wdata,
   output logic [7:0]        cb_min,
   output logic [7:0]        cb_max,
   output logic [7:0]        cr_min,
   output logic [7:0]        cr_max,
   output logic              proc_en,
   output logic              bypass,
   output logic              cfg_pending,
   output logic              commit_pulse,
   output logic              locked,
   output logic [W_BITS-1:0] meas_width,
   output logic [H_BITS-1:0] meas_height
);

   localparam logic [3:0]        LOCK_N  = 4'(LOCK_FRAMES);
   localparam logic [W_BITS-1:0] PIX_MAX = '1;
   localparam logic [H_BITS-1:0] LIN_MAX = '1;

   logic [7:0]        r_sh_cb_min, r_sh_cb_max, r_sh_cr_min, r_sh_cr_max;
   logic              r_sh_en, r_sh_byp, r_en;
   logic              r_vs_d, r_de_d, r_seen_vs, r_frame_bad;
   logic [W_BITS-1:0] r_pix_cnt, r_ref_width, r_prev_width;
   logic [H_BITS-1:0] r_line_cnt, r_prev_height;
   logic [3:0]        r_stable_cnt;

   logic              w_vs_rise, w_de_fall, w_wr_ok, w_commit, w_good, w_en_nxt;
   logic [3:0]        w_stable_nxt;

   assign w_vs_rise = in_vsync & ~r_vs_d;
   assign w_de_fall = ~in_de & r_de_d;
   assign w_wr_ok   = cfg_we & (cfg_addr <= 3'd4);
   assign w_commit  = w_vs_rise & cfg_pending;
   assign w_en_nxt  = w_commit ? r_sh_en : r_en;
   assign w_good    = ~r_frame_bad & (r_line_cnt != '0) &
                      (r_ref_width == r_prev_width) & (r_line_cnt == r_prev_height);

   always_comb begin
      w_stable_nxt = r_stable_cnt;
      if (w_vs_rise) begin
         if (!w_good)                    w_stable_nxt = 4'd0;
         else if (r_stable_cnt != LOCK_N) w_stable_nxt = r_stable_cnt + 4'd1;
      end
   end

   // Shadow registers, commit to active, and the registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_cb_min  <= 8'(CB_MIN_DEF);
         r_sh_cb_max  <= 8'(CB_MAX_DEF);
         r_sh_cr_min  <= 8'(CR_MIN_DEF);
         r_sh_cr_max  <= 8'(CR_MAX_DEF);
         r_sh_en      <= 1'b1;
         r_sh_byp     <= 1'b0;
         cb_min       <= 8'(CB_MIN_DEF);
         cb_max       <= 8'(CB_MAX_DEF);
         cr_min       <= 8'(CR_MIN_DEF);
         cr_max       <= 8'(CR_MAX_DEF);
         r_en         <= 1'b1;
         bypass       <= 1'b0;
         cfg_pending  <= 1'b0;
         commit_pulse <= 1'b0;
         r_stable_cnt <= 4'd0;
         locked       <= 1'b0;
         proc_en      <= 1'b0;
      end else begin
         commit_pulse <= w_commit;
         // The commit copies the pre-write shadow; a same-cycle write stays pending.
         if (w_commit) begin
            cb_min      <= r_sh_cb_min;
            cb_max      <= r_sh_cb_max;
            cr_min      <= r_sh_cr_min;
            cr_max      <= r_sh_cr_max;
            r_en        <= r_sh_en;
            bypass      <= r_sh_byp;
            cfg_pending <= 1'b0;
         end
         if (w_wr_ok) begin
            cfg_pending <= 1'b1;
            case (cfg_addr)
               3'd0:    r_sh_cb_min <= cfg_wdata;
               3'd1:    r_sh_cb_max <= cfg_wdata;
               3'd2:    r_sh_cr_min <= cfg_wdata;
               3'd3:    r_sh_cr_max <= cfg_wdata;
               default: begin
                  r_sh_en  <= cfg_wdata[0];
                  r_sh_byp <= cfg_wdata[1];
               end
            endcase
         end
         r_stable_cnt <= w_stable_nxt;
         locked       <= (w_stable_nxt == LOCK_N);
         proc_en      <= w_en_nxt & (w_stable_nxt == LOCK_N);
      end
   end

   // Timing measurement; the first vsync after reset only starts a clean frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d        <= 1'b0;
         r_de_d        <= 1'b0;
         r_seen_vs     <= 1'b0;
         r_frame_bad   <= 1'b0;
         r_pix_cnt     <= '0;
         r_line_cnt    <= '0;
         r_ref_width   <= '0;
         r_prev_width  <= '0;
         r_prev_height <= '0;
         meas_width    <= '0;
         meas_height   <= '0;
      end else begin
         r_vs_d <= in_vsync;
         r_de_d <= in_de;
         if (w_vs_rise) begin
            r_seen_vs <= 1'b1;
            if (r_seen_vs) begin
               meas_width    <= r_ref_width;
               meas_height   <= r_line_cnt;
               r_prev_width  <= r_ref_width;
               r_prev_height <= r_line_cnt;
            end
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_frame_bad <= 1'b0;
         end else begin
            if (in_de) begin
               if (r_pix_cnt == PIX_MAX) r_frame_bad <= 1'b1;
               else                      r_pix_cnt   <= r_pix_cnt + W_BITS'(1);
            end
            if (w_de_fall) begin
               if (r_line_cnt == '0)              r_ref_width <= r_pix_cnt;
               else if (r_pix_cnt != r_ref_width) r_frame_bad <= 1'b1;
               if (r_line_cnt == LIN_MAX) r_frame_bad <= 1'b1;
               else                       r_line_cnt  <= r_line_cnt + H_BITS'(1);
               r_pix_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_skin_seg_ctrl.sv
// Directed testbench for skin_seg_ctrl: commit timing, same-cycle write/commit,
// lock acquisition/loss on 64x48 frames, bypass gating and asynchronous reset.
module tb_skin_seg_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_de = 1'b0;
   logic        in_vsync = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [7:0]  cfg_wdata = 8'd0;
   logic [7:0]  cb_min, cb_max, cr_min, cr_max;
   logic        proc_en, bypass, cfg_pending, commit_pulse, locked;
   logic [11:0] meas_width;
   logic [10:0] meas_height;

   int n_pass = 0;
   int n_total = 0;

   skin_seg_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_vsync(in_vsync),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
      .proc_en(proc_en), .bypass(bypass), .cfg_pending(cfg_pending),
      .commit_pulse(commit_pulse), .locked(locked),
      .meas_width(meas_width), .meas_height(meas_height)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; in_de = 1'b0; in_vsync = 1'b0; cfg_we = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [7:0] data);
      cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
      tick();
      cfg_we = 1'b0;
   endtask

   // Blanking, n_lines lines of 64 pixels (line bad_line has 63), then vsync rises;
   // returns just after the vs_rise edge so the caller sees the updated status.
   task automatic frame(input int n_lines, input int bad_line);
      in_vsync = 1'b0;
      tick(); tick();
      for (int l = 0; l < n_lines; l++) begin
         in_de = 1'b1;
         repeat ((l == bad_line) ? 63 : 64) tick();
         in_de = 1'b0;
         repeat (3) tick();
      end
      in_vsync = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      apply_reset();
      n_total++; if (cb_min !== 8'd77) $display("FAIL reset_cb_min got %0d want 77", cb_min); else n_pass++;
      n_total++; if (cb_max !== 8'd127) $display("FAIL reset_cb_max got %0d want 127", cb_max); else n_pass++;
      n_total++; if (cr_min !== 8'd133) $display("FAIL reset_cr_min got %0d want 133", cr_min); else n_pass++;
      n_total++; if (cr_max !== 8'd173) $display("FAIL reset_cr_max got %0d want 173", cr_max); else n_pass++;
      n_total++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else n_pass++;
      n_total++; if (proc_en !== 1'b0) $display("FAIL reset_proc_en got %b want 0", proc_en); else n_pass++;
      n_total++; if (cfg_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", cfg_pending); else n_pass++;
      n_total++; if (meas_width !== 12'd0) $display("FAIL reset_meas_width got %0d want 0", meas_width); else n_pass++;
   endtask

   task automatic test_commit();
      in_vsync = 1'b0;
      tick(); tick();
      in_de = 1'b1; tick(); tick();
      cfg_write(3'd0, 8'd90);
      cfg_write(3'd6, 8'd11);
      in_de = 1'b0; tick();
      n_total++; if (cb_min !== 8'd77) $display("FAIL commit_hold_cb_min got %0d want 77", cb_min); else n_pass++;
      n_total++; if (cfg_pending !== 1'b1) $display("FAIL commit_pending_set got %b want 1", cfg_pending); else n_pass++;
      in_vsync = 1'b1;
      tick();
      n_total++; if (cb_min !== 8'd90) $display("FAIL commit_cb_min got %0d want 90", cb_min); else n_pass++;
      n_total++; if (commit_pulse !== 1'b1) $display("FAIL commit_pulse_high got %b want 1", commit_pulse); else n_pass++;
      n_total++; if (cfg_pending !== 1'b0) $display("FAIL commit_pending_clr got %b want 0", cfg_pending); else n_pass++;
      tick();
      n_total++; if (commit_pulse !== 1'b0) $display("FAIL commit_pulse_one got %b want 0", commit_pulse); else n_pass++;
      // Write to an unmapped address alone must not set pending.
      in_vsync = 1'b0; tick();
      cfg_write(3'd7, 8'd1);
      n_total++; if (cfg_pending !== 1'b0) $display("FAIL bad_addr_pending got %b want 0", cfg_pending); else n_pass++;
   endtask

   task automatic test_same_cycle();
      in_vsync = 1'b0;
      tick(); tick();
      in_vsync = 1'b1;
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 8'd200;
      tick();
      cfg_we = 1'b0;
      n_total++; if (cr_max !== 8'd173) $display("FAIL same_cr_max got %0d want 173", cr_max); else n_pass++;
      n_total++; if (cfg_pending !== 1'b1) $display("FAIL same_pending got %b want 1", cfg_pending); else n_pass++;
      n_total++; if (commit_pulse !== 1'b0) $display("FAIL same_no_pulse got %b want 0", commit_pulse); else n_pass++;
      frame(2, -1);
      n_total++; if (cr_max !== 8'd200) $display("FAIL same_next_cr_max got %0d want 200", cr_max); else n_pass++;
      n_total++; if (commit_pulse !== 1'b1) $display("FAIL same_next_pulse got %b want 1", commit_pulse); else n_pass++;
   endtask

   task automatic test_lock();
      apply_reset();
      frame(0, -1);
      frame(48, -1);
      n_total++; if (meas_width !== 12'd64) $display("FAIL lock_meas_width got %0d want 64", meas_width); else n_pass++;
      n_total++; if (meas_height !== 11'd48) $display("FAIL lock_meas_height got %0d want 48", meas_height); else n_pass++;
      frame(48, -1);
      frame(48, -1);
      n_total++; if (locked !== 1'b0) $display("FAIL lock_early got %b want 0", locked); else n_pass++;
      frame(48, -1);
      n_total++; if (locked !== 1'b1) $display("FAIL lock_4th got %b want 1", locked); else n_pass++;
      n_total++; if (proc_en !== 1'b1) $display("FAIL lock_proc_en got %b want 1", proc_en); else n_pass++;
   endtask

   task automatic test_unlock();
      frame(48, 10);
      n_total++; if (locked !== 1'b0) $display("FAIL unlock_locked got %b want 0", locked); else n_pass++;
      n_total++; if (proc_en !== 1'b0) $display("FAIL unlock_proc_en got %b want 0", proc_en); else n_pass++;
      n_total++; if (meas_width !== 12'd64) $display("FAIL unlock_meas_width got %0d want 64", meas_width); else n_pass++;
      frame(48, -1);
      frame(48, -1);
      n_total++; if (locked !== 1'b0) $display("FAIL relock_early got %b want 0", locked); else n_pass++;
      frame(48, -1);
      n_total++; if (locked !== 1'b1) $display("FAIL relock got %b want 1", locked); else n_pass++;
      n_total++; if (proc_en !== 1'b1) $display("FAIL relock_proc_en got %b want 1", proc_en); else n_pass++;
   endtask

   task automatic test_bypass_and_async_reset();
      in_vsync = 1'b0; tick();
      cfg_write(3'd4, 8'h02);
      frame(48, -1);
      n_total++; if (bypass !== 1'b1) $display("FAIL bypass_set got %b want 1", bypass); else n_pass++;
      n_total++; if (locked !== 1'b1) $display("FAIL bypass_locked got %b want 1", locked); else n_pass++;
      n_total++; if (proc_en !== 1'b0) $display("FAIL bypass_proc_en got %b want 0", proc_en); else n_pass++;
      in_vsync = 1'b0; tick();
      in_de = 1'b1; tick(); tick();
      cfg_write(3'd0, 8'd5);
      rst_n = 1'b0;
      #2;
      n_total++; if (cb_min !== 8'd77) $display("FAIL areset_cb_min got %0d want 77", cb_min); else n_pass++;
      n_total++; if (bypass !== 1'b0) $display("FAIL areset_bypass got %b want 0", bypass); else n_pass++;
      n_total++; if (locked !== 1'b0) $display("FAIL areset_locked got %b want 0", locked); else n_pass++;
      n_total++; if (cfg_pending !== 1'b0) $display("FAIL areset_pending got %b want 0", cfg_pending); else n_pass++;
      n_total++; if (meas_height !== 11'd0) $display("FAIL areset_meas_height got %0d want 0", meas_height); else n_pass++;
      in_de = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_commit();
      test_same_cycle();
      test_lock();
      test_unlock();
      test_bypass_and_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
